// File: rtl/sim_to_seq_reg_pkg.sv
// Shared definitions for the parallel-to-serial word emitter.
// Holds the state encoding, direction constants and small constant helpers.
package sim_to_seq_reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DIR_FORWARD  = 1;
    localparam int DIR_BACKWARD = 0;

    // Any positive value counts as true; zero and negatives count as false.
    function automatic bit val2bool(input int v);
        return (v > 0);
    endfunction

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sim_to_seq_reg_word_counter.sv
// Loadable down-counter tracking the words still held after the current one.
// Synchronous clear has priority over load, load over decrement.
module sim_to_seq_reg_word_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, reload for a new frame, or step down on consume.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/sim_to_seq_reg.sv
// Parallel-to-serial word emitter: captures a BIT_WIDTH*SHIFT_LEN frame in one
// load cycle and emits it one BIT_WIDTH word per enabled cycle.
// DIRECTION > 0 emits the top slice first, otherwise the bottom slice first.
// Optional macro SIM_TO_SEQ_REG_PS_FIRST_EN: the first slice bypasses storage
// and appears combinationally in the load cycle; loads only from IDLE.
module sim_to_seq_reg
    import sim_to_seq_reg_pkg::*;
#(
    parameter int    DIRECTION   = DIR_FORWARD,
    parameter int    SHIFT_LEN   = 1,
    parameter int    BIT_WIDTH   = 2,
    parameter string OUTTER_NAME = "",
    parameter string MODULE_NAME = ""
) (
    input  logic                           clk,
    input  logic                           in_ctr_Srst,
    input  logic                           in_ctr_en,
    input  logic                           in_ctr_load,
    input  logic [BIT_WIDTH*SHIFT_LEN-1:0] in,
    output logic [BIT_WIDTH-1:0]           out,
    output logic                           out_valid,
    output logic                           out_last,
    output logic                           out_ack,
    output logic                           out_busy
);

    localparam int W     = BIT_WIDTH * SHIFT_LEN;
    localparam int CNT_W = clog2_min1(SHIFT_LEN);
    localparam bit FWD   = val2bool(DIRECTION);
`ifdef SIM_TO_SEQ_REG_PS_FIRST_EN
    // The first word leaves in the load cycle, so one fewer remains stored.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((SHIFT_LEN > 1) ? SHIFT_LEN - 2 : 0);
`else
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SHIFT_LEN - 1);
`endif

    state_e           state_q;
    state_e           state_d;
    logic [W-1:0]     store_q;
    logic [W-1:0]     store_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic             shifting;
    logic             stored_last;
    logic             load_ok;
    logic             accept;
    logic [BIT_WIDTH-1:0] head_word;

    // Move the next slice into the head position of the storage register.
    function automatic logic [W-1:0] advance(input logic [W-1:0] v);
        return FWD ? (v << BIT_WIDTH) : (v >> BIT_WIDTH);
    endfunction

    assign shifting    = (state_q == ST_SHIFT);
    assign stored_last = shifting & cnt_zero;
    assign head_word   = FWD ? store_q[W-1 -: BIT_WIDTH] : store_q[BIT_WIDTH-1:0];

`ifdef SIM_TO_SEQ_REG_PS_FIRST_EN
    logic [BIT_WIDTH-1:0] in_first_word;
    assign in_first_word = FWD ? in[W-1 -: BIT_WIDTH] : in[BIT_WIDTH-1:0];
    assign load_ok       = ~shifting;
`else
    // Back-to-back: a new frame may land while the final stored word leaves.
    assign load_ok       = ~shifting | stored_last;
`endif

    assign accept   = in_ctr_load & in_ctr_en & ~in_ctr_Srst & load_ok;
    assign out_ack  = accept;
    assign out_busy = shifting;

    // Next-state, storage and counter control; reset dominates any load.
    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (in_ctr_Srst) begin
            state_d = ST_IDLE;
            store_d = '0;
        end else if (accept) begin
            cnt_load = 1'b1;
`ifdef SIM_TO_SEQ_REG_PS_FIRST_EN
            store_d = advance(in);
            if (SHIFT_LEN > 1) begin
                state_d = ST_SHIFT;
            end else begin
                state_d = ST_IDLE;
            end
`else
            store_d = in;
            state_d = ST_SHIFT;
`endif
        end else if (shifting && in_ctr_en) begin
            if (cnt == '0) begin
                state_d = ST_IDLE;
                store_d = '0;
            end else begin
                store_d = advance(store_q);
                cnt_dec = 1'b1;
            end
        end
    end

    // State and frame storage registers.
    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            state_q <= ST_IDLE;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
        end
    end

    sim_to_seq_reg_word_counter #(
        .CNT_W (CNT_W)
    ) u_word_counter (
        .clk      (clk),
        .clr      (in_ctr_Srst),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .is_zero  (cnt_zero)
    );

    // Output mux: head of storage while shifting, zero otherwise.
    always_comb begin
        out_valid = shifting;
        out_last  = stored_last;
        out       = shifting ? head_word : '0;
`ifdef SIM_TO_SEQ_REG_PS_FIRST_EN
        if (accept) begin
            out_valid = 1'b1;
            out_last  = (SHIFT_LEN == 1);
            out       = in_first_word;
        end
`endif
    end

endmodule

// File: tb/tb_sim_to_seq_reg.sv
// Scoreboard bench for sim_to_seq_reg: forward and backward 4x3 instances and
// a single-word forward instance. Expected words are queued when a load is
// issued; monitors pop on every consumed word (out_valid & en).
module tb_sim_to_seq_reg;
    import sim_to_seq_reg_pkg::*;

`ifdef SIM_TO_SEQ_REG_PS_FIRST_EN
    localparam bit PS       = 1'b1;
    localparam int LAST_OFS = 2;
`else
    localparam bit PS       = 1'b0;
    localparam int LAST_OFS = 3;
`endif

    typedef struct packed {
        logic [3:0] word;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        srst, en, load, load1;
    logic [11:0] din;
    logic [3:0]  din1;

    logic [3:0]  out_f, out_b, out_1;
    logic        vld_f, vld_b, vld_1;
    logic        last_f, last_b, last_1;
    logic        ack_f, ack_b, ack_1;
    logic        busy_f, busy_b, busy_1;

    exp_t q_f[$];
    exp_t q_b[$];
    exp_t q_1[$];
    exp_t e_f, e_b, e_1;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  mon_on = 1'b0;

    always #5 clk = ~clk;

    sim_to_seq_reg #(.DIRECTION(DIR_FORWARD), .SHIFT_LEN(3), .BIT_WIDTH(4),
                     .OUTTER_NAME("tb"), .MODULE_NAME("fwd")) u_fwd (
        .clk(clk), .in_ctr_Srst(srst), .in_ctr_en(en), .in_ctr_load(load), .in(din),
        .out(out_f), .out_valid(vld_f), .out_last(last_f), .out_ack(ack_f), .out_busy(busy_f));

    sim_to_seq_reg #(.DIRECTION(DIR_BACKWARD), .SHIFT_LEN(3), .BIT_WIDTH(4),
                     .OUTTER_NAME("tb"), .MODULE_NAME("bwd")) u_bwd (
        .clk(clk), .in_ctr_Srst(srst), .in_ctr_en(en), .in_ctr_load(load), .in(din),
        .out(out_b), .out_valid(vld_b), .out_last(last_b), .out_ack(ack_b), .out_busy(busy_b));

    sim_to_seq_reg #(.DIRECTION(DIR_FORWARD), .SHIFT_LEN(1), .BIT_WIDTH(4),
                     .OUTTER_NAME("tb"), .MODULE_NAME("one")) u_one (
        .clk(clk), .in_ctr_Srst(srst), .in_ctr_en(en), .in_ctr_load(load1), .in(din1),
        .out(out_1), .out_valid(vld_1), .out_last(last_1), .out_ack(ack_1), .out_busy(busy_1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue the hand-ordered words of a 3-slice frame for both directions.
    task automatic push_frame(input logic [11:0] f);
        exp_t e;
        for (int i = 2; i >= 0; i--) begin
            e.word = f[i*4 +: 4];
            e.last = (i == 0);
            q_f.push_back(e);
        end
        for (int i = 0; i <= 2; i++) begin
            e.word = f[i*4 +: 4];
            e.last = (i == 2);
            q_b.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (vld_f) begin
                if (q_f.size() == 0) check("fwd_unexpected_word", 1, 0);
                else if (en) begin
                    e_f = q_f.pop_front();
                    check("fwd_word", out_f, e_f.word);
                    check("fwd_last", last_f, e_f.last);
                end else check("fwd_hold", out_f, q_f[0].word);
            end else check("fwd_idle_zero", {out_f, last_f}, 0);
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (vld_b) begin
                if (q_b.size() == 0) check("bwd_unexpected_word", 1, 0);
                else if (en) begin
                    e_b = q_b.pop_front();
                    check("bwd_word", out_b, e_b.word);
                    check("bwd_last", last_b, e_b.last);
                end else check("bwd_hold", out_b, q_b[0].word);
            end else check("bwd_idle_zero", {out_b, last_b}, 0);
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (vld_1) begin
                if (q_1.size() == 0) check("one_unexpected_word", 1, 0);
                else if (en) begin
                    e_1 = q_1.pop_front();
                    check("one_word", out_1, e_1.word);
                    check("one_last", last_1, e_1.last);
                end else check("one_hold", out_1, q_1[0].word);
            end else check("one_idle_zero", {out_1, last_1}, 0);
        end
    end

    initial begin
        exp_t e;
        srst = 1'b1; en = 1'b0; load = 1'b0; load1 = 1'b0; din = '0; din1 = '0;
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        check("rst_fwd", {out_f, vld_f, last_f, ack_f, busy_f}, 0);
        check("rst_bwd", {out_b, vld_b, last_b, ack_b, busy_b}, 0);
        check("rst_one", {out_1, vld_1, last_1, ack_1, busy_1}, 0);
        mon_on = 1'b1;

        // Basic frame, both directions; ack in the load cycle, idle afterwards.
        tick(); load = 1'b1; en = 1'b1; din = 12'hCBA; push_frame(12'hCBA);
        @(negedge clk);
        check("t1_ack_fwd", ack_f, 1);
        check("t1_ack_bwd", ack_b, 1);
        tick(); load = 1'b0;
        @(negedge clk);
        check("t1_valid_next", vld_f, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t2_busy_fwd_done", busy_f, 0);
        check("t2_busy_bwd_done", busy_b, 0);

        // Stall: en low for two cycles after the load.
        tick(); load = 1'b1; en = 1'b1; din = 12'hCBA; push_frame(12'hCBA);
        tick(); load = 1'b0; en = 1'b0;
        tick();
        tick(); en = 1'b1;
        repeat (4) tick();
        check("t3_busy_done", busy_f, 0);

        // Load in the final-word cycle: back-to-back unless passing-first.
        tick(); load = 1'b1; en = 1'b1; din = 12'hCBA; push_frame(12'hCBA);
        tick(); load = 1'b0;
        repeat (LAST_OFS - 1) tick();
        load = 1'b1; din = 12'h321;
        if (!PS) push_frame(12'h321);
        @(negedge clk);
        check("t4_last_at_reload", last_f, 1);
        check("t4_ack_b2b", ack_f, PS ? 0 : 1);
        tick(); load = 1'b0;
        @(negedge clk);
        check("t4_no_bubble", vld_f, PS ? 0 : 1);
        repeat (4) tick();

        // Reset mid-frame together with a load.
        tick(); load = 1'b1; en = 1'b1; din = 12'hCBA; push_frame(12'hCBA);
        tick(); load = 1'b0;
        tick(); srst = 1'b1; load = 1'b1; din = 12'h321;
        @(negedge clk);
        check("t5_ack_under_rst_fwd", ack_f, 0);
        check("t5_ack_under_rst_bwd", ack_b, 0);
        tick(); srst = 1'b0; load = 1'b0;
        @(negedge clk);
        check("t5_post_rst_fwd", {out_f, vld_f, last_f, busy_f}, 0);
        check("t5_post_rst_bwd", {out_b, vld_b, last_b, busy_b}, 0);
        q_f.delete();
        q_b.delete();

        // Single-word frames.
        tick(); load1 = 1'b1; en = 1'b1; din1 = 4'h7;
        e.word = 4'h7; e.last = 1'b1; q_1.push_back(e);
        @(negedge clk);
        check("t6_one_ack", ack_1, 1);
        tick(); load1 = 1'b0;
        @(negedge clk);
        check("t6_one_valid_next", vld_1, PS ? 0 : 1);
        tick();
        check("t6_one_busy_done", busy_1, 0);
        tick(); load1 = 1'b1; din1 = 4'h9;
        e.word = 4'h9; e.last = 1'b1; q_1.push_back(e);
        tick(); load1 = 1'b0; en = 1'b0;
        tick(); en = 1'b1;
        repeat (2) tick();

        repeat (5) tick();
        check("drain_fwd", q_f.size(), 0);
        check("drain_bwd", q_b.size(), 0);
        check("drain_one", q_1.size(), 0);
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
